// File: rtl/inst_fetch_pkg.sv
// Shared types for the dual-issue fetch front end: widths, queue entry layout
// and the decode slot-count encoding.
package inst_fetch_pkg;

  localparam int PC_W   = 32;
  localparam int INST_W = 32;

  // dec_accept encoding; ACC_MAX is legal on the port and treated as two slots.
  typedef enum logic [1:0] {
    ACC_NONE = 2'd0,
    ACC_ONE  = 2'd1,
    ACC_TWO  = 2'd2,
    ACC_MAX  = 2'd3
  } slot_cnt_e;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic [1:0] clamp_slots(input logic [1:0] n);
    return (n == ACC_MAX) ? ACC_TWO : n;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular buffer of {pc, inst} entries with a 2-wide write port and a
// 2-wide read window at the head.
module fetch_queue
  import inst_fetch_pkg::*;
#(
  parameter  int QDEPTH = 8,
  localparam int AW     = $clog2(QDEPTH),
  localparam int CW     = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t wdata0,
  input  fetch_entry_t wdata1,
  input  logic [1:0]   pop,
  input  logic         flush,
  output fetch_entry_t rdata0,
  output fetch_entry_t rdata1,
  output logic [CW-1:0] count
);

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  fetch_entry_t  mem_q [QDEPTH];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + AW'(2);
      head_d  = head_q + AW'(pop);
      count_d = count_q + (push ? CW'(2) : CW'(0)) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) begin
      mem_q[tail_q]          <= wdata0;
      mem_q[tail_q + AW'(1)] <= wdata1;
    end
  end

  assign rdata0 = mem_q[head_q];
  assign rdata1 = mem_q[head_q + AW'(1)];
  assign count  = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Dual-issue fetch front end: drives the ROM pair address, buffers replies and
// presents up to two {pc, inst} slots to decode; handles redirect and back-pressure.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [PC_W-1:0] PC_STEP  = 32'd4,
  parameter int              QDEPTH   = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PC_W-1:0]   pc,
  output logic [PC_W-1:0]   pc_4,
  input  logic [INST_W-1:0] inst1,
  input  logic [INST_W-1:0] inst2,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic [1:0]        dec_accept,
  output logic              out_valid1,
  output logic [PC_W-1:0]   out_pc1,
  output logic [INST_W-1:0] out_inst1,
  output logic              out_valid2,
  output logic [PC_W-1:0]   out_pc2,
  output logic [INST_W-1:0] out_inst2
);

  localparam int CW = $clog2(QDEPTH) + 1;

  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   count;
  logic [CW-1:0]   free;
  logic [1:0]      acc;
  logic [1:0]      pop;
  logic            push;
  fetch_entry_t    wdata0, wdata1, rdata0, rdata1;

  // Free space is judged on the pre-pop count, so a pair is only fetched when
  // both slots are guaranteed regardless of what decode takes this cycle.
  assign free = CW'(QDEPTH) - count;
  assign push = !rst && !redirect_valid && (free >= CW'(2));
  assign acc  = clamp_slots(dec_accept);

  always_comb begin
    pop = 2'd0;
    if (!redirect_valid) begin
      pop = (count >= CW'(acc)) ? acc : count[1:0];
    end
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid)  fetch_pc_d = redirect_pc;
    else if (push)       fetch_pc_d = fetch_pc_q + (PC_STEP << 1);
  end

  always_ff @(posedge clk) begin
    if (rst) fetch_pc_q <= RESET_PC;
    else     fetch_pc_q <= fetch_pc_d;
  end

  assign pc   = fetch_pc_q;
  assign pc_4 = fetch_pc_q + PC_STEP;

  assign wdata0 = '{pc: pc,   inst: inst1};
  assign wdata1 = '{pc: pc_4, inst: inst2};

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .wdata0 (wdata0),
    .wdata1 (wdata1),
    .pop    (pop),
    .flush  (redirect_valid),
    .rdata0 (rdata0),
    .rdata1 (rdata1),
    .count  (count)
  );

  assign out_valid1 = (count >= CW'(1));
  assign out_valid2 = (count >= CW'(2));
  assign out_pc1    = out_valid1 ? rdata0.pc   : '0;
  assign out_inst1  = out_valid1 ? rdata0.inst : '0;
  assign out_pc2    = out_valid2 ? rdata1.pc   : '0;
  assign out_inst2  = out_valid2 ? rdata1.inst : '0;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed vector table for the documented corner cases,
// then randomized traffic against a queue-based reference model.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, pc_4, inst1, inst2;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [1:0]  dec_accept;
  logic        out_valid1, out_valid2;
  logic [31:0] out_pc1, out_inst1, out_pc2, out_inst2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign inst1 = rom(pc);
  assign inst2 = rom(pc_4);

  inst_fetch #(.RESET_PC(32'h0), .PC_STEP(32'd4), .QDEPTH(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .pc_4           (pc_4),
    .inst1          (inst1),
    .inst2          (inst2),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_accept     (dec_accept),
    .out_valid1     (out_valid1),
    .out_pc1        (out_pc1),
    .out_inst1      (out_inst1),
    .out_valid2     (out_valid2),
    .out_pc2        (out_pc2),
    .out_inst2      (out_inst2)
  );

  typedef struct {
    logic        r;
    logic        rv;
    logic [31:0] rpc;
    logic [1:0]  acc;
    logic        v1;
    logic        v2;
    logic [31:0] pc1;
    logic [31:0] pc2;
    logic [31:0] fpc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic rv, input logic [31:0] rpc,
                              input logic [1:0] acc, input logic v1, input logic v2,
                              input logic [31:0] pc1, input logic [31:0] pc2,
                              input logic [31:0] fpc);
    vec_t v;
    v.r = r; v.rv = rv; v.rpc = rpc; v.acc = acc;
    v.v1 = v1; v.v2 = v2; v.pc1 = pc1; v.pc2 = pc2; v.fpc = fpc;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_cycle(input logic r, input logic rv, input logic [31:0] rpc,
                             input logic [1:0] acc);
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    dec_accept     = acc;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic v1, input logic v2,
                             input logic [31:0] pc1, input logic [31:0] pc2,
                             input logic [31:0] fpc);
    chk({tag, " valid1"}, 32'(out_valid1), 32'(v1));
    chk({tag, " valid2"}, 32'(out_valid2), 32'(v2));
    chk({tag, " pc"},     pc,   fpc);
    chk({tag, " pc_4"},   pc_4, fpc + 32'd4);
    chk({tag, " out_pc1"},   out_pc1,   v1 ? pc1 : 32'h0);
    chk({tag, " out_inst1"}, out_inst1, v1 ? rom(pc1) : 32'h0);
    chk({tag, " out_pc2"},   out_pc2,   v2 ? pc2 : 32'h0);
    chk({tag, " out_inst2"}, out_inst2, v2 ? rom(pc2) : 32'h0);
  endtask

  // Reference model: a plain list of fetched {pc, inst} pairs plus the next fetch address.
  logic [31:0] m_pc;
  logic [63:0] mq[$];

  task automatic model_step(input logic r, input logic rv, input logic [31:0] rpc,
                            input logic [1:0] acc);
    int free_slots, npop;
    if (r) begin
      m_pc = 32'h0;
      mq.delete();
    end else if (rv) begin
      m_pc = rpc;
      mq.delete();
    end else begin
      free_slots = 8 - mq.size();
      npop = (int'(acc) > 2) ? 2 : int'(acc);
      if (npop > mq.size()) npop = mq.size();
      for (int k = 0; k < npop; k++) void'(mq.pop_front());
      if (free_slots >= 2) begin
        mq.push_back({m_pc, rom(m_pc)});
        mq.push_back({m_pc + 32'd4, rom(m_pc + 32'd4)});
        m_pc = m_pc + 32'd8;
      end
    end
  endtask

  initial begin
    logic        r, rv, e_v1, e_v2;
    logic [31:0] rpc, e_pc1, e_pc2;
    logic [1:0]  acc;

    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; dec_accept = 2'd0;

    //   r  rv  rpc            acc  v1 v2 pc1            pc2            fetch_pc
    add(1, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0,        32'h0);
    add(0, 0, 32'h0,        0, 1, 1, 32'h0,        32'h4,        32'h8);
    add(0, 0, 32'h0,        0, 1, 1, 32'h0,        32'h4,        32'h10);
    add(0, 0, 32'h0,        0, 1, 1, 32'h0,        32'h4,        32'h18);
    add(0, 0, 32'h0,        0, 1, 1, 32'h0,        32'h4,        32'h20);
    add(0, 0, 32'h0,        0, 1, 1, 32'h0,        32'h4,        32'h20);
    add(0, 0, 32'h0,        0, 1, 1, 32'h0,        32'h4,        32'h20);
    add(0, 0, 32'h0,        1, 1, 1, 32'h4,        32'h8,        32'h20);
    add(0, 0, 32'h0,        1, 1, 1, 32'h8,        32'hC,        32'h20);
    add(0, 0, 32'h0,        0, 1, 1, 32'h8,        32'hC,        32'h28);
    add(0, 1, 32'h40,       2, 0, 0, 32'h0,        32'h0,        32'h40);
    add(0, 0, 32'h0,        0, 1, 1, 32'h40,       32'h44,       32'h48);
    add(0, 0, 32'h0,        2, 1, 1, 32'h48,       32'h4C,       32'h50);
    add(0, 0, 32'h0,        2, 1, 1, 32'h50,       32'h54,       32'h58);
    add(0, 0, 32'h0,        3, 1, 1, 32'h58,       32'h5C,       32'h60);
    add(0, 1, 32'hFFFF_FFF8, 0, 0, 0, 32'h0,       32'h0,        32'hFFFF_FFF8);
    add(0, 0, 32'h0,        0, 1, 1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0);
    add(0, 0, 32'h0,        2, 1, 1, 32'h0,        32'h4,        32'h8);
    add(0, 0, 32'h0,        0, 1, 1, 32'h0,        32'h4,        32'h10);
    add(0, 0, 32'h0,        1, 1, 1, 32'h4,        32'h8,        32'h18);
    add(1, 1, 32'h80,       2, 0, 0, 32'h0,        32'h0,        32'h0);
    add(0, 0, 32'h0,        0, 1, 1, 32'h0,        32'h4,        32'h8);
    add(0, 0, 32'h0,        1, 1, 1, 32'h4,        32'h8,        32'h10);
    add(0, 0, 32'h0,        2, 1, 1, 32'hC,        32'h10,       32'h18);

    foreach (vecs[i]) begin
      drive_cycle(vecs[i].r, vecs[i].rv, vecs[i].rpc, vecs[i].acc);
      check_state($sformatf("vec%0d", i), vecs[i].v1, vecs[i].v2,
                  vecs[i].pc1, vecs[i].pc2, vecs[i].fpc);
    end

    // Randomized traffic; start from a known reset so the model and DUT agree.
    drive_cycle(1'b1, 1'b0, 32'h0, 2'd0);
    model_step(1'b1, 1'b0, 32'h0, 2'd0);
    for (int n = 0; n < 1500; n++) begin
      r   = ($urandom_range(0, 63) == 0);
      rv  = ($urandom_range(0, 15) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? $urandom() : {$urandom_range(0, 4095), 2'b00};
      acc = 2'($urandom_range(0, 3));
      drive_cycle(r, rv, rpc, acc);
      model_step(r, rv, rpc, acc);
      e_v1  = (mq.size() >= 1);
      e_v2  = (mq.size() >= 2);
      e_pc1 = e_v1 ? mq[0][63:32] : 32'h0;
      e_pc2 = e_v2 ? mq[1][63:32] : 32'h0;
      check_state($sformatf("rnd%0d", n), e_v1, e_v2, e_pc1, e_pc2, m_pc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
